// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage program-counter unit.
// Holds the default reset/trap addresses and the next-PC source select.
package pc_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_TRAP  = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_HOLD  = 3'd2,
        SEL_RAS   = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// replace rewrites the top in place, flush empties the stack.
module ras_stack #(
    parameter int BW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic          replace,
    input  logic [BW-1:0] wr_data,
    output logic [BW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          wr_en_s;
    logic [PW-1:0] wr_idx_s;
    logic [BW-1:0] mem_r [DEPTH];

    assign empty = (cnt_r == {CW{1'b0}});
    assign full  = (cnt_r == CW'(DEPTH));
    assign top   = mem_r[ptr_r];

    // Next pointer/count and write port selection; flush dominates.
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        if (flush) begin
            ptr_nxt_s = {PW{1'b0}};
            cnt_nxt_s = {CW{1'b0}};
        end else if (push) begin
            // When full the slot after top holds the oldest entry, so it is reused.
            ptr_nxt_s = ptr_r + PW'(1);
            wr_idx_s  = ptr_r + PW'(1);
            wr_en_s   = 1'b1;
            if (full) begin
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end else if (replace && !empty) begin
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_r;
        end else if (pop && !empty) begin
            ptr_nxt_s = ptr_r - PW'(1);
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {PW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter unit: picks the next PC from trap, redirect, stall,
// RAS pop or sequential increment, and drives the return-address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int            BW        = 32,
    parameter logic [BW-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [BW-1:0] TRAP_VEC  = TRAP_VEC_DEF,
    parameter int            INC       = 4,
    parameter int            RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          trap,
    input  logic          redirect_valid,
    input  logic [BW-1:0] redirect_pc,
    input  logic          call,
    input  logic          ret,
    output logic [BW-1:0] PC_out,
    output logic          pc_valid,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_underflow
);

    logic [BW-1:0] pc_r;
    logic [BW-1:0] pc_nxt_s;
    logic [BW-1:0] pc_seq_s;
    logic          pc_valid_r;
    logic          underflow_r;
    logic          underflow_nxt_s;
    pc_sel_e       sel_s;
    logic          ras_push_s;
    logic          ras_pop_s;
    logic          ras_replace_s;
    logic          ras_flush_s;
    logic [BW-1:0] ras_top_s;
    logic          ras_empty_s;
    logic          ras_full_s;
    logic          low_prio_s;

    assign pc_seq_s      = pc_r + BW'(INC);
    assign PC_out        = pc_r;
    assign pc_valid      = pc_valid_r;
    assign ras_underflow = underflow_r;
    assign ras_empty     = ras_empty_s;
    assign ras_full      = ras_full_s;

    // Source select and RAS control; before the first valid cycle everything holds.
    always_comb begin
        sel_s           = SEL_HOLD;
        low_prio_s      = 1'b0;
        ras_flush_s     = 1'b0;
        ras_push_s      = 1'b0;
        ras_pop_s       = 1'b0;
        ras_replace_s   = 1'b0;
        underflow_nxt_s = 1'b0;
        if (!pc_valid_r) begin
            sel_s = SEL_HOLD;
        end else if (trap) begin
            sel_s       = SEL_TRAP;
            ras_flush_s = 1'b1;
        end else if (redirect_valid) begin
            sel_s = SEL_REDIR;
        end else if (stall) begin
            sel_s = SEL_HOLD;
        end else begin
            low_prio_s = 1'b1;
            if (ret && !ras_empty_s) begin
                sel_s         = SEL_RAS;
                ras_replace_s = call;
                ras_pop_s     = !call;
            end else begin
                sel_s           = SEL_SEQ;
                ras_push_s      = call;
                underflow_nxt_s = ret;
            end
        end
    end

    // Next-PC mux; redirect_pc only reaches state on the redirect path.
    always_comb begin
        pc_nxt_s = pc_r;
        case (sel_s)
            SEL_TRAP:  pc_nxt_s = TRAP_VEC;
            SEL_REDIR: pc_nxt_s = redirect_pc;
            SEL_HOLD:  pc_nxt_s = pc_r;
            SEL_RAS:   pc_nxt_s = ras_top_s;
            SEL_SEQ:   pc_nxt_s = pc_seq_s;
            default:   pc_nxt_s = pc_r;
        endcase
    end

    // PC, valid and underflow pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            pc_valid_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pc_r        <= pc_nxt_s;
            pc_valid_r  <= 1'b1;
            underflow_r <= underflow_nxt_s;
        end
    end

    ras_stack #(
        .BW    (BW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .flush   (ras_flush_s),
        .push    (ras_push_s),
        .pop     (ras_pop_s),
        .replace (ras_replace_s),
        .wr_data (pc_seq_s),
        .top     (ras_top_s),
        .empty   (ras_empty_s),
        .full    (ras_full_s)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, call/return, RAS overflow/underflow,
// event priority, stall, PC wrap and mid-operation reset.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        call;
    logic        ret;
    logic [31:0] PC_out;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;

    int total;
    int bad;

    pc_gen #(
        .BW        (32),
        .RESET_PC  (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .trap           (trap),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .call           (call),
        .ret            (ret),
        .PC_out         (PC_out),
        .pc_valid       (pc_valid),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .ras_underflow  (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; trap = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; call = 1'b0; ret = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_full", {31'b0, ras_full}, 32'h0);
        chk("rst_uflow", {31'b0, ras_underflow}, 32'h0);

        // Release: PC 0 (valid=0), 0 (valid=1), 4, 8.
        rst = 1'b0;
        chk("rel_pc0", PC_out, 32'h0);
        tick();
        chk("rel_pc1", PC_out, 32'h0);
        chk("rel_valid", {31'b0, pc_valid}, 32'h1);
        tick();
        chk("rel_pc2", PC_out, 32'h4);
        tick();
        chk("rel_pc3", PC_out, 32'h8);
        chk("rel_empty", {31'b0, ras_empty}, 32'h1);
        tick();
        tick();
        chk("at_10", PC_out, 32'h10);

        // Call at 0x10, two idles, return to 0x14.
        call = 1'b1;
        tick();
        call = 1'b0;
        chk("call_pc", PC_out, 32'h14);
        chk("call_nonempty", {31'b0, ras_empty}, 32'h0);
        tick();
        chk("idle_18", PC_out, 32'h18);
        tick();
        chk("idle_1c", PC_out, 32'h1C);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("ret_pc", PC_out, 32'h14);
        chk("ret_empty", {31'b0, ras_empty}, 32'h1);

        // Five calls from PC 0 into a 4-deep stack.
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        idle();
        chk("redir_0", PC_out, 32'h0);
        call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("call_seq", PC_out, 32'(4 * (i + 1)));
        end
        call = 1'b0;
        chk("ovf_full", {31'b0, ras_full}, 32'h1);
        ret = 1'b1;
        tick();
        chk("pop0", PC_out, 32'h14);
        chk("pop0_notfull", {31'b0, ras_full}, 32'h0);
        tick();
        chk("pop1", PC_out, 32'h10);
        tick();
        chk("pop2", PC_out, 32'hC);
        tick();
        chk("pop3", PC_out, 32'h8);
        chk("pop3_empty", {31'b0, ras_empty}, 32'h1);
        chk("pop3_uflow", {31'b0, ras_underflow}, 32'h0);
        tick();
        ret = 1'b0;
        chk("pop4_seq", PC_out, 32'hC);
        chk("pop4_uflow", {31'b0, ras_underflow}, 32'h1);
        tick();
        chk("uflow_clr", {31'b0, ras_underflow}, 32'h0);
        chk("after_uflow", PC_out, 32'h10);

        // Trap beats redirect and stall, and flushes the stack.
        call = 1'b1;
        tick();
        chk("pre_trap_push", {31'b0, ras_empty}, 32'h0);
        trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
        tick();
        chk("trap_pc", PC_out, 32'h100);
        chk("trap_flush", {31'b0, ras_empty}, 32'h1);
        trap = 1'b0; call = 1'b0;
        tick();
        idle();
        chk("redir_stall", PC_out, 32'h200);

        // Stall with call for 3 cycles pushes nothing.
        call = 1'b1;
        tick();
        chk("push_204", PC_out, 32'h204);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", PC_out, 32'h204);
        end
        chk("stall_full", {31'b0, ras_full}, 32'h0);
        idle();
        tick();
        chk("post_stall", PC_out, 32'h208);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("stall_pop", PC_out, 32'h204);
        chk("stall_one_entry", {31'b0, ras_empty}, 32'h1);

        // Wrap modulo 2^32.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        idle();
        chk("at_fffc", PC_out, 32'hFFFF_FFFC);
        tick();
        chk("wrap", PC_out, 32'h0);

        // Reset coinciding with ret on a non-empty stack.
        call = 1'b1;
        tick();
        call = 1'b0;
        chk("mid_push", PC_out, 32'h4);
        ret = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst_pc", PC_out, 32'h0);
        chk("mid_rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
        rst = 1'b0; ret = 1'b0;
        tick();
        chk("mid_rel_pc", PC_out, 32'h0);
        tick();
        chk("mid_rel_seq", PC_out, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
